// File: rtl/axi4_lite_regbank.sv
// axi4_lite_regbank: AXI4-Lite slave register file with byte strobes, error responses and write pulses.
// Optional AXI4L_PROT_CHECK_EN rejects unprivileged accesses (PROT[0]=0) with SLVERR.
module axi4_lite_regbank #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 8,
    parameter int                 N_REGS  = 5,
    parameter logic [N_REGS-1:0]  RO_MASK = '0,
    parameter logic [DATA_W-1:0]  REG_RST = '0
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                 S_AXI_AWPROT,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_W-1:0]          S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                 S_AXI_ARPROT,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    input  logic                       i_is_busy,
    input  logic [N_REGS*DATA_W-1:0]   i_ro_data,
    output logic [N_REGS*DATA_W-1:0]   o_regs,
    output logic [N_REGS-1:0]          o_wr_pulse
);
    localparam int NB  = DATA_W / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_W - LSB;

    logic                      aw_held, w_held, aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]         aw_addr_q, w_addr;
    logic [DATA_W-1:0]         w_data_q, w_data, r_src;
    logic [NB-1:0]             w_strb_q, w_strb;
    logic [N_REGS*DATA_W-1:0]  regs_q;
    logic [IW-1:0]             w_idx, r_idx;
    logic                      w_map, w_ro, r_map, w_prot_ok, r_prot_ok, w_ok;
    logic [1:0]                w_resp;
    logic                      unused;

    assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !S_AXI_ARESET && !S_AXI_RVALID;
    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);
    assign w_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign w_data = w_held ? w_data_q : S_AXI_WDATA;
    assign w_strb = w_held ? w_strb_q : S_AXI_WSTRB;
    assign w_idx  = w_addr[ADDR_W-1:LSB];
    assign r_idx  = S_AXI_ARADDR[ADDR_W-1:LSB];

`ifdef AXI4L_PROT_CHECK_EN
    logic aw_priv_q;
    always_ff @(posedge S_AXI_ACLK)
        if (aw_hs) aw_priv_q <= S_AXI_AWPROT[0];
    assign w_prot_ok = aw_held ? aw_priv_q : S_AXI_AWPROT[0];
    assign r_prot_ok = S_AXI_ARPROT[0];
`else
    assign w_prot_ok = 1'b1;
    assign r_prot_ok = 1'b1;
`endif

    always_comb begin
        w_map = 1'b0;
        w_ro  = 1'b0;
        r_map = 1'b0;
        r_src = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_idx == IW'(i)) begin
                w_map = 1'b1;
                w_ro  = RO_MASK[i];
            end
            if (r_idx == IW'(i)) begin
                r_map = 1'b1;
                r_src = o_regs[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ok   = w_map && !w_ro && !i_is_busy && w_prot_ok;
    assign w_resp = !w_map ? 2'b11 : (w_ok ? 2'b00 : 2'b10);

    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    // Commit only ever fires with BVALID low, since both READYs are gated by it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            o_wr_pulse   <= '0;
            regs_q       <= {N_REGS{REG_RST}};
        end else begin
            o_wr_pulse <= '0;
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= w_resp;
                for (int i = 0; i < N_REGS; i++)
                    if (w_ok && w_idx == IW'(i)) begin
                        o_wr_pulse[i] <= 1'b1;
                        for (int k = 0; k < NB; k++)
                            if (w_strb[k]) regs_q[i*DATA_W + k*8 +: 8] <= w_data[k*8 +: 8];
                    end
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs) w_held <= 1'b1;
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RRESP  <= !r_map ? 2'b11 : ((i_is_busy || !r_prot_ok) ? 2'b10 : 2'b00);
            S_AXI_RDATA  <= (r_map && !i_is_busy && r_prot_ok) ? r_src : '0;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_out
        assign o_regs[i*DATA_W +: DATA_W] = RO_MASK[i] ? i_ro_data[i*DATA_W +: DATA_W]
                                                       : regs_q[i*DATA_W +: DATA_W];
    end

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_addr, S_AXI_ARADDR, i_ro_data, regs_q};
endmodule

// File: tb/tb_axi4_lite_regbank.sv
// tb_axi4_lite_regbank: directed plus randomized checks of axi4_lite_regbank against a register-array model.
module tb_axi4_lite_regbank;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, busy;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [159:0] ro_data, regs;
    logic [4:0]   pulse;

    logic [31:0]  m [4];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    axi4_lite_regbank #(
        .DATA_W(32), .ADDR_W(8), .N_REGS(5), .RO_MASK(5'b10000), .REG_RST(32'h0)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .i_is_busy(busy), .i_ro_data(ro_data), .o_regs(regs), .o_wr_pulse(pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] exp_regs();
        logic [159:0] f;
        for (int i = 0; i < 4; i++) f[i*32 +: 32] = m[i];
        f[128 +: 32] = ro_data[128 +: 32];
        return f;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold);
        int idx, cyc;
        logic [1:0] er;
        logic [4:0] ep;
        bit aw_done, w_done;
        idx = int'(addr) / 4;
        er = (idx >= 5) ? 2'b11 : ((idx == 4 || busy) ? 2'b10 : 2'b00);
        ep = '0;
        aw_done = 0;
        w_done = 0;
        cyc = 0;
        awaddr = addr;
        wdata = data;
        wstrb = strb;
        while (!bvalid && cyc < 30) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid = !w_done && cyc >= w_dly;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            tick();
            cyc++;
        end
        awvalid = 0;
        wvalid = 0;
        if (er == 2'b00) begin
            m[idx] = merge(m[idx], data, strb);
            ep[idx] = 1'b1;
        end
        check("bvalid_set", bvalid, 1'b1);
        check("write_latency", cyc, (aw_dly > w_dly ? aw_dly : w_dly) + 1);
        check("bresp", bresp, er);
        check("wr_pulse", pulse, ep);
        check("regs_after_write", regs, exp_regs());
        for (int h = 0; h < b_hold; h++) begin
            tick();
            check("bvalid_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, er);
            check("aw_w_ready_hold", {awready, wready}, 2'b00);
            check("pulse_one_cycle", pulse, 5'b0);
        end
        bready = 1;
        tick();
        bready = 0;
        check("bvalid_clear", bvalid, 1'b0);
        check("pulse_clear", pulse, 5'b0);
    endtask

    task automatic do_read(input logic [7:0] addr, input int r_hold);
        int idx, cyc;
        logic [31:0] ed;
        logic [1:0] er;
        idx = int'(addr) / 4;
        if (idx >= 5) begin ed = 0; er = 2'b11; end
        else if (busy) begin ed = 0; er = 2'b10; end
        else if (idx == 4) begin ed = ro_data[128 +: 32]; er = 2'b00; end
        else begin ed = m[idx]; er = 2'b00; end
        araddr = addr;
        arvalid = 1;
        cyc = 0;
        while (!arready && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        arvalid = 0;
        check("rvalid_set", rvalid, 1'b1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        check("arready_busy", arready, 1'b0);
        for (int h = 0; h < r_hold; h++) begin
            tick();
            check("r_hold", {rvalid, rresp, rdata}, {1'b1, er, ed});
        end
        rready = 1;
        tick();
        rready = 0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        logic [31:0] old;
        rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0; busy = 0;
        ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        repeat (3) tick();
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resps", {bresp, rresp}, 4'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", pulse, 5'b0);
        check("rst_regs", regs, exp_regs());
        rst = 0;
        #1;
        check("post_rst_readies", {awready, wready, arready}, 3'b111);

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("reg1_literal", regs[63:32], 32'hDEADBEEF);
        do_write(8'h08, 32'h12345678, 4'hF, 3, 0, 4);
        do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(8'h00, 32'h00000000, 4'h5, 0, 0, 1);
        check("strb_literal", regs[31:0], 32'hFF00FF00);
        do_read(8'h00, 1);
        do_write(8'h14, 32'h11111111, 4'hF, 0, 1, 0);
        do_write(8'h10, 32'h22222222, 4'hF, 1, 0, 0);
        busy = 1;
        do_write(8'h00, 32'h33333333, 4'hF, 0, 0, 0);
        busy = 0;
        do_read(8'h40, 0);
        do_read(8'h10, 0);
        do_write(8'h0C, 32'h00000000, 4'h0, 0, 0, 0);

        old = m[3];
        awaddr = 8'h0C; wdata = 32'hAAAA5555; wstrb = 4'hF; araddr = 8'h0C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("conc_bvalid", {bvalid, bresp}, 3'b100);
        check("conc_rvalid", {rvalid, rresp}, 3'b100);
        check("conc_old_data", rdata, old);
        m[3] = 32'hAAAA5555;
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        do_read(8'h0C, 0);

        awaddr = 8'h04; awvalid = 1;
        tick();
        awvalid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_bvalid", bvalid, 1'b0);
        end
        check("midrst_regs", regs, exp_regs());
        do_write(8'h04, 32'h55AA55AA, 4'hF, 2, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 6) * 4 + $urandom_range(0, 3));
            busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
            busy = 0;
        end
        check("final_regs", regs, exp_regs());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/axi4_lite_regbank.md
Name: axi4_lite_regbank

Overview:
Parametrised AXI4-Lite slave with an internal register file of N_REGS words. Generalises the single-beat adder-control slave:
- Fully independent AW/W acceptance.
- Byte-strobe writes applied internally.
- BVALID/RVALID held until the master handshakes.
- DECERR for unmapped addresses, SLVERR for read-only or busy targets.
- Per-register write pulses to the datapath.
Sits between the PS AXI interconnect and the adder control/datapath.

Parameters:
DATA_W, 32, AXI data width (32 or 64).
ADDR_W, 8, AXI address width.
N_REGS, 5, number of mapped registers (1..64).
RO_MASK, 0, N_REGS-bit mask; bit i set = register i is read-only, sourced from i_ro_data.
REG_RST, 0, reset value of every writable register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  write protection
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  read protection
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
i_is_busy  in  1  datapath busy
i_ro_data  in  N_REGS*DATA_W  read-only register sources; slice i is used when RO_MASK[i]=1
o_regs  out  N_REGS*DATA_W  register file contents, flattened
o_wr_pulse  out  N_REGS  one-cycle pulse per successfully written register

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESET is synchronous and active-high.
- Reset values:
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - o_wr_pulse=0; writable registers = REG_RST.
  - AWREADY/WREADY/ARREADY are 0 while reset is high and 1 on the first cycle after release.
- Reset mid-transaction: pending captures and responses are discarded; no response is issued.
- Addressing:
  - Index = ADDR[ADDR_W-1:log2(DATA_W/8)]; the low byte-offset bits are ignored.
  - Index >= N_REGS -> DECERR (2'b11).
- Write path:
  - Flags aw_held/w_held latch AW and W independently, in either order or together.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - Commit happens on the first edge where both address and data are available, held or handshaking that edge. At commit:
    - Response is computed, BVALID is set, and both flags are cleared.
    - AW+W on the same edge t gives BVALID=1 from cycle t+1.
  - Response priority at commit: DECERR (unmapped) > SLVERR (RO_MASK bit set, or i_is_busy=1 at the commit edge) > OKAY.
  - Only OKAY updates the register and asserts o_wr_pulse[idx] for exactly one cycle, aligned with BVALID rising.
  - Byte k is updated only if WSTRB[k]=1. WSTRB=0 still returns OKAY and still pulses.
  - BVALID and BRESP stay stable until BREADY; they clear on the edge where BVALID&&BREADY.
- Read path:
  - ARREADY = !RVALID.
  - AR handshake at edge t: RDATA/RRESP are registered and RVALID=1 from cycle t+1.
  - RDATA source: RO register -> i_ro_data slice; unmapped -> 0 with DECERR.
  - i_is_busy=1 at the AR edge -> SLVERR with RDATA=0.
  - RVALID, RDATA and RRESP are held stable until RREADY. Maximum throughput is one read per 2 cycles.
- Simultaneous events:
  - Read and write channels are independent.
  - A read of a register committed on the same edge returns the pre-write value.
- AWPROT/ARPROT are ignored unless the optional feature is enabled.

Optional Feature:
AXI4L_PROT_CHECK_EN
- Defined: the PROT value is captured with the address. PROT[0]=0 (unprivileged) yields SLVERR, with no write, no pulse, and RDATA=0. This SLVERR ranks below DECERR.
- Undefined: PROT is unused; no extra state is synthesised.

Test Plan:
- Reset then single write: AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb 0xF -> BVALID next cycle, BRESP=OKAY, o_wr_pulse=5'b00010, o_regs[1]=0xDEADBEEF.
- Order independence: W first (data 0x12345678), AW 3 cycles later (addr 0x08) -> single commit, OKAY, o_regs[2]=0x12345678. Hold BREADY=0 for 4 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout.
- Strobes: reg0=0xFFFFFFFF, write 0x00000000 with strb 0x5 -> reg0=0xFF00FF00. Readback at 0x00 -> RDATA=0xFF00FF00, OKAY.
- Errors:
  - Write to 0x14 -> DECERR, no pulse.
  - Write with RO_MASK=5'b10000 at 0x10 -> SLVERR, no change.
  - Write at 0x00 with i_is_busy=1 -> SLVERR.
  - Read at 0x40 -> DECERR, RDATA=0.
- Concurrency: write 0xAAAA5555 to 0x0C on the same edge as a read of 0x0C -> RDATA=old value. The next read returns 0xAAAA5555.
- Reset mid-write: AW accepted, reset pulsed before W -> no BVALID. Registers = REG_RST. A subsequent full write completes normally.
